// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: serialises PTW, data and fetch requests onto one
// backend port, fixed priority PTW > dmem > fetch with a starvation guard for fetch.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ptw_request,
  input  logic [31:0] ptw_addr,
  input  logic        dmem_request,
  input  logic        dmem_request_type,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_write_data,
  input  logic [3:0]  dmem_write_mask,
  input  logic        fetch_request,
  input  logic [31:0] fetch_addr,
  output logic        ptw_grant,
  output logic        dmem_grant,
  output logic        fetch_grant,
  output logic        ptw_data_valid,
  output logic        dmem_data_valid,
  output logic        fetch_data_valid,
  output logic [31:0] request_data,
  output logic        mem_request,
  output logic        mem_request_type,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_write_mask,
  input  logic        mem_ready,
  input  logic        mem_data_valid,
  input  logic [31:0] mem_read_data,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_PTW, OWN_DMEM, OWN_FETCH} owner_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t      state, state_next;
  owner_t      owner, win_owner;
  logic        first_issue;
  logic        arb_win;
  logic        capture;
  logic [3:0]  starve_cnt, starve_next;
  logic [31:0] lat_addr, win_addr;
  logic        lat_type, win_type;
  logic [31:0] lat_wdata, win_wdata;
  logic [3:0]  lat_mask, win_mask;

  // Backend handshake: mem_request is held with stable mem_* fields until a
  // cycle where mem_ready is high; mem_data_valid counts only in that cycle
  // (ISSUE) or any later cycle of WAIT, and is ignored everywhere else.
  always_comb begin
    state_next = state;
    arb_win    = 1'b0;
    capture    = 1'b0;
    win_owner  = OWN_NONE;
    win_addr   = fetch_addr;
    win_type   = 1'b0;
    win_wdata  = 32'h0;
    win_mask   = 4'h0;

    if (fetch_request && (starve_cnt == STARVE_MAX)) win_owner = OWN_FETCH;
    else if (ptw_request)                             win_owner = OWN_PTW;
    else if (dmem_request)                            win_owner = OWN_DMEM;
    else if (fetch_request)                           win_owner = OWN_FETCH;

    case (win_owner)
      OWN_PTW: win_addr = ptw_addr;
      OWN_DMEM: begin
        win_addr  = dmem_addr;
        win_type  = dmem_request_type;
        win_wdata = dmem_write_data;
        win_mask  = dmem_request_type ? dmem_write_mask : 4'h0;
      end
      default: ;
    endcase

    // Fetch losing while asking builds pressure; anything else relieves it.
    if (win_owner == OWN_FETCH || !fetch_request) starve_next = 4'h0;
    else if (starve_cnt < STARVE_MAX)              starve_next = starve_cnt + 4'd1;
    else                                           starve_next = starve_cnt;

    case (state)
      IDLE: begin
        if (win_owner != OWN_NONE) begin
          arb_win    = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_ready) begin
          if (mem_data_valid) begin
            capture    = 1'b1;
            state_next = RESP;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_data_valid) begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      owner        <= OWN_NONE;
      first_issue  <= 1'b0;
      starve_cnt   <= 4'h0;
      lat_addr     <= 32'h0;
      lat_type     <= 1'b0;
      lat_wdata    <= 32'h0;
      lat_mask     <= 4'h0;
      request_data <= 32'h0;
    end else begin
      state       <= state_next;
      first_issue <= arb_win;
      if (arb_win) begin
        owner      <= win_owner;
        starve_cnt <= starve_next;
        lat_addr   <= win_addr;
        lat_type   <= win_type;
        lat_wdata  <= win_wdata;
        lat_mask   <= win_mask;
      end
      if (capture) request_data <= mem_read_data;
    end
  end

  assign mem_request      = (state == ISSUE);
  assign mem_request_type = lat_type;
  assign mem_addr         = lat_addr;
  assign mem_write_data   = lat_wdata;
  assign mem_write_mask   = lat_mask;

  assign ptw_grant   = first_issue && (state == ISSUE) && (owner == OWN_PTW);
  assign dmem_grant  = first_issue && (state == ISSUE) && (owner == OWN_DMEM);
  assign fetch_grant = first_issue && (state == ISSUE) && (owner == OWN_FETCH);

  assign ptw_data_valid   = (state == RESP) && (owner == OWN_PTW);
  assign dmem_data_valid  = (state == RESP) && (owner == OWN_DMEM);
  assign fetch_data_valid = (state == RESP) && (owner == OWN_FETCH);

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: priority, starvation guard, writes, backend
// stalls and asynchronous reset during a transaction.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ptw_request, dmem_request, dmem_request_type, fetch_request;
  logic [31:0] ptw_addr, dmem_addr, dmem_write_data, fetch_addr;
  logic [3:0]  dmem_write_mask;
  logic        ptw_grant, dmem_grant, fetch_grant;
  logic        ptw_data_valid, dmem_data_valid, fetch_data_valid;
  logic [31:0] request_data;
  logic        mem_request, mem_request_type;
  logic [31:0] mem_addr, mem_write_data;
  logic [3:0]  mem_write_mask;
  logic        mem_ready, mem_data_valid;
  logic [31:0] mem_read_data;
  logic        busy;
  logic [1:0]  dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .ptw_request(ptw_request), .ptw_addr(ptw_addr),
    .dmem_request(dmem_request), .dmem_request_type(dmem_request_type),
    .dmem_addr(dmem_addr), .dmem_write_data(dmem_write_data),
    .dmem_write_mask(dmem_write_mask),
    .fetch_request(fetch_request), .fetch_addr(fetch_addr),
    .ptw_grant(ptw_grant), .dmem_grant(dmem_grant), .fetch_grant(fetch_grant),
    .ptw_data_valid(ptw_data_valid), .dmem_data_valid(dmem_data_valid),
    .fetch_data_valid(fetch_data_valid), .request_data(request_data),
    .mem_request(mem_request), .mem_request_type(mem_request_type),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_write_mask(mem_write_mask), .mem_ready(mem_ready),
    .mem_data_valid(mem_data_valid), .mem_read_data(mem_read_data),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] ctrl_vec();
    return {ptw_grant, dmem_grant, fetch_grant, ptw_data_valid, dmem_data_valid,
            fetch_data_valid, mem_request, mem_request_type, busy};
  endfunction

  // ---------------- driver: backend + requester drop ----------------
  // Called in an IDLE cycle with requests already driven; runs one transaction
  // and returns in the following IDLE cycle.
  task automatic run_txn(input int ready_delay, input int data_delay,
                         input logic [31:0] rdata, input bit hold,
                         output logic [2:0] g_vec, output int g_cnt,
                         output logic [2:0] v_vec, output int v_cnt,
                         output logic [31:0] v_data, output int lat,
                         output logic [31:0] i_addr, output logic i_type,
                         output logic [31:0] i_wdata, output logic [3:0] i_mask,
                         output bit stable, output int i_cycles, output bit done);
    logic [2:0] g, v;
    int wc;
    bit seen;
    g_vec = '0; g_cnt = 0; v_vec = '0; v_cnt = 0; v_data = '0; lat = 0;
    i_addr = '0; i_type = 1'b0; i_wdata = '0; i_mask = '0;
    stable = 1'b1; i_cycles = 0; done = 1'b0; wc = 0; seen = 1'b0;
    for (int k = 1; k <= 40 && !done; k++) begin
      tick();
      g = {ptw_grant, dmem_grant, fetch_grant};
      v = {ptw_data_valid, dmem_data_valid, fetch_data_valid};
      g_vec |= g;
      g_cnt += $countones(g);
      v_cnt += $countones(v);
      mem_ready = 1'b0;
      mem_data_valid = 1'b0;
      if (seen) begin
        if (!busy) done = 1'b1;
      end else if (v != 3'b000) begin
        v_vec = v; v_data = request_data; lat = k; seen = 1'b1;
        if (!hold) begin
          if (v[2]) ptw_request = 1'b0;
          if (v[1]) dmem_request = 1'b0;
          if (v[0]) fetch_request = 1'b0;
        end
      end else if (mem_request) begin
        if (i_cycles == 0) begin
          i_addr = mem_addr; i_type = mem_request_type;
          i_wdata = mem_write_data; i_mask = mem_write_mask;
        end else if (mem_addr !== i_addr || mem_request_type !== i_type ||
                     mem_write_data !== i_wdata || mem_write_mask !== i_mask) begin
          stable = 1'b0;
        end
        if (i_cycles == ready_delay) begin
          mem_ready = 1'b1;
          mem_data_valid = (data_delay == 0);
          mem_read_data = rdata;
        end
        i_cycles++;
      end else if (busy) begin
        wc++;
        if (wc == data_delay) begin
          mem_data_valid = 1'b1;
          mem_read_data = rdata;
        end
      end
    end
  endtask

  // transaction result holders
  logic [2:0]  r_g, r_v;
  int          r_gc, r_vc, r_lat, r_ic;
  logic [31:0] r_data, r_addr, r_wdata;
  logic        r_type;
  logic [3:0]  r_mask;
  bit          r_stable, r_done;

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    ptw_request = 0; dmem_request = 0; fetch_request = 0; dmem_request_type = 0;
    ptw_addr = '0; dmem_addr = '0; fetch_addr = '0; dmem_write_data = '0;
    dmem_write_mask = '0; mem_ready = 0; mem_data_valid = 0; mem_read_data = '0;
    repeat (3) tick();
    tests_run++;
    if (ctrl_vec() !== 9'h0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b expected %b", ctrl_vec(), 9'h0);
    end
    tests_run++;
    if ({mem_addr, mem_write_data, mem_write_mask, request_data} !== 100'h0) begin
      tests_failed++;
      $display("FAIL reset_data: got addr=%h wdata=%h mask=%h rdata=%h expected all 0",
               mem_addr, mem_write_data, mem_write_mask, request_data);
    end
    tests_run++;
    if (dbg_state !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got %0d expected 0", dbg_state);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_fetch_read();
    fetch_request = 1'b1; fetch_addr = 32'h0000_0100;
    run_txn(0, 2, 32'hDEAD_BEEF, 1'b0, r_g, r_gc, r_v, r_vc, r_data, r_lat,
            r_addr, r_type, r_wdata, r_mask, r_stable, r_ic, r_done);
    tests_run++;
    if (r_done !== 1'b1) begin
      tests_failed++; $display("FAIL fetch_done: got %0d expected 1", r_done);
    end
    tests_run++;
    if (r_g !== 3'b001 || r_gc != 1) begin
      tests_failed++; $display("FAIL fetch_grant: got %b x%0d expected 001 x1", r_g, r_gc);
    end
    tests_run++;
    if (r_v !== 3'b001 || r_vc != 1) begin
      tests_failed++; $display("FAIL fetch_valid: got %b x%0d expected 001 x1", r_v, r_vc);
    end
    tests_run++;
    if (r_lat != 4) begin
      tests_failed++; $display("FAIL fetch_latency: got %0d expected 4", r_lat);
    end
    tests_run++;
    if (r_data !== 32'hDEAD_BEEF) begin
      tests_failed++; $display("FAIL fetch_data: got %h expected deadbeef", r_data);
    end
    tests_run++;
    if (r_addr !== 32'h100 || r_type !== 1'b0 || r_mask !== 4'h0) begin
      tests_failed++;
      $display("FAIL fetch_issue: got addr=%h type=%b mask=%h expected 100/0/0",
               r_addr, r_type, r_mask);
    end
    tests_run++;
    if (busy !== 1'b0 || request_data !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL fetch_hold: got busy=%b data=%h expected 0/deadbeef", busy, request_data);
    end
  endtask

  task automatic test_priority();
    logic [2:0]  exp_own [3] = '{3'b100, 3'b010, 3'b001};
    logic [31:0] exp_adr [3] = '{32'h0000_1000, 32'h0000_2000, 32'h0000_3000};
    logic [31:0] exp_dat [3] = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
    ptw_request = 1; ptw_addr = 32'h0000_1000;
    dmem_request = 1; dmem_request_type = 0; dmem_addr = 32'h0000_2000;
    dmem_write_data = 32'hFFFF_FFFF; dmem_write_mask = 4'hF;
    fetch_request = 1; fetch_addr = 32'h0000_3000;
    for (int i = 0; i < 3; i++) begin
      run_txn(0, 0, exp_dat[i], 1'b0, r_g, r_gc, r_v, r_vc, r_data, r_lat,
              r_addr, r_type, r_wdata, r_mask, r_stable, r_ic, r_done);
      tests_run++;
      if (r_g !== exp_own[i] || r_gc != 1) begin
        tests_failed++;
        $display("FAIL prio_grant[%0d]: got %b x%0d expected %b x1", i, r_g, r_gc, exp_own[i]);
      end
      tests_run++;
      if (r_v !== exp_own[i] || r_vc != 1 || r_lat != 2) begin
        tests_failed++;
        $display("FAIL prio_valid[%0d]: got %b x%0d lat %0d expected %b x1 lat 2",
                 i, r_v, r_vc, r_lat, exp_own[i]);
      end
      tests_run++;
      if (r_addr !== exp_adr[i] || r_mask !== 4'h0 || r_type !== 1'b0) begin
        tests_failed++;
        $display("FAIL prio_issue[%0d]: got addr=%h mask=%h type=%b expected %h/0/0",
                 i, r_addr, r_mask, r_type, exp_adr[i]);
      end
      tests_run++;
      if (r_data !== exp_dat[i]) begin
        tests_failed++;
        $display("FAIL prio_data[%0d]: got %h expected %h", i, r_data, exp_dat[i]);
      end
    end
  endtask

  task automatic test_dmem_write();
    dmem_request = 1; dmem_request_type = 1; dmem_addr = 32'h0000_0040;
    dmem_write_data = 32'h1234_5678; dmem_write_mask = 4'b0011;
    run_txn(0, 1, 32'h5555_5555, 1'b0, r_g, r_gc, r_v, r_vc, r_data, r_lat,
            r_addr, r_type, r_wdata, r_mask, r_stable, r_ic, r_done);
    dmem_request_type = 0;
    tests_run++;
    if (r_type !== 1'b1 || r_addr !== 32'h40) begin
      tests_failed++;
      $display("FAIL write_cmd: got type=%b addr=%h expected 1/00000040", r_type, r_addr);
    end
    tests_run++;
    if (r_wdata !== 32'h1234_5678 || r_mask !== 4'b0011) begin
      tests_failed++;
      $display("FAIL write_payload: got data=%h mask=%b expected 12345678/0011", r_wdata, r_mask);
    end
    tests_run++;
    if (r_g !== 3'b010 || r_v !== 3'b010 || r_lat != 3) begin
      tests_failed++;
      $display("FAIL write_ack: got grant=%b valid=%b lat=%0d expected 010/010/3", r_g, r_v, r_lat);
    end
  endtask

  task automatic test_starvation();
    logic [9:0] fetch_pat = '0;
    logic [9:0] dmem_pat = '0;
    dmem_request = 1; dmem_request_type = 0; dmem_addr = 32'h0000_0800;
    fetch_request = 1; fetch_addr = 32'h0000_0900;
    for (int i = 0; i < 10; i++) begin
      run_txn(0, 0, 32'h0, 1'b1, r_g, r_gc, r_v, r_vc, r_data, r_lat,
              r_addr, r_type, r_wdata, r_mask, r_stable, r_ic, r_done);
      fetch_pat = {fetch_pat[8:0], (r_g === 3'b001)};
      dmem_pat  = {dmem_pat[8:0],  (r_g === 3'b010)};
    end
    dmem_request = 0; fetch_request = 0;
    tests_run++;
    if (fetch_pat !== 10'b0000100001) begin
      tests_failed++; $display("FAIL starve_fetch: got %b expected 0000100001", fetch_pat);
    end
    tests_run++;
    if (dmem_pat !== 10'b1111011110) begin
      tests_failed++; $display("FAIL starve_dmem: got %b expected 1111011110", dmem_pat);
    end
    tick();
  endtask

  task automatic test_ready_stall();
    fetch_request = 1; fetch_addr = 32'h0000_0200;
    run_txn(5, 0, 32'h0BAD_CAFE, 1'b0, r_g, r_gc, r_v, r_vc, r_data, r_lat,
            r_addr, r_type, r_wdata, r_mask, r_stable, r_ic, r_done);
    tests_run++;
    if (r_gc != 1 || r_g !== 3'b001) begin
      tests_failed++; $display("FAIL stall_grant: got %b x%0d expected 001 x1", r_g, r_gc);
    end
    tests_run++;
    if (r_stable !== 1'b1 || r_ic != 6 || r_addr !== 32'h200) begin
      tests_failed++;
      $display("FAIL stall_request: got stable=%b cycles=%0d addr=%h expected 1/6/200",
               r_stable, r_ic, r_addr);
    end
    tests_run++;
    if (r_lat != 7 || r_v !== 3'b001 || r_data !== 32'h0BAD_CAFE) begin
      tests_failed++;
      $display("FAIL stall_complete: got lat=%0d valid=%b data=%h expected 7/001/0badcafe",
               r_lat, r_v, r_data);
    end
  endtask

  task automatic test_reset_mid();
    fetch_request = 1; fetch_addr = 32'h0000_0300;
    tick();
    fetch_request = 0; mem_ready = 1; mem_data_valid = 0;
    tick();
    mem_ready = 0;
    tests_run++;
    if (busy !== 1'b1 || mem_request !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_wait: got busy=%b req=%b expected 1/0", busy, mem_request);
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if (ctrl_vec() !== 9'h0 || dbg_state !== 2'd0) begin
      tests_failed++;
      $display("FAIL midrst_ctrl: got %b state %0d expected 0 / 0", ctrl_vec(), dbg_state);
    end
    tests_run++;
    if (mem_addr !== 32'h0 || request_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL midrst_data: got addr=%h rdata=%h expected 0/0", mem_addr, request_data);
    end
    #1;
    reset = 1'b1;
    mem_data_valid = 1; mem_read_data = 32'hBAD0_0BAD;
    for (int i = 0; i < 3; i++) begin
      tick();
      mem_data_valid = 0;
      tests_run++;
      if (ctrl_vec() !== 9'h0 || request_data !== 32'h0) begin
        tests_failed++;
        $display("FAIL midrst_stray[%0d]: got ctrl=%b rdata=%h expected 0/0",
                 i, ctrl_vec(), request_data);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_fetch_read();
    test_priority();
    test_dmem_write();
    test_starvation();
    test_ready_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
